restoring_divider: RTL and testbench

Sequential unsigned restoring divider: the subtract-and-shift counterpart of the team's ripple-carry adder datapath. It accepts a WIDTH-bit dividend and divisor on a start pulse and iterates one quotient bit per clock. It returns quotient and remainder with a one-cycle done pulse. It sits beside the adder in the lab arithmetic unit and can optionally drive the existing seven_seg display with the quotient.

---
 rtl/restoring_divider_pkg.sv | 13 +
 rtl/restoring_divider_if.sv | 28 ++
 rtl/restoring_divider_sub_step.sv | 25 ++
 rtl/seven_seg.sv | 31 +++
 rtl/restoring_divider.sv | 145 ++++++++++++++
 tb/tb_restoring_divider.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: controller states
// and the default operand width.
package restoring_divider_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ZERO
    } div_state_e;

endpackage

// File: rtl/restoring_divider_if.sv
// Request/result bundle of the restoring divider. The master issues operands
// and start; the slave (the divider) returns busy, done and the results.
interface restoring_divider_if
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/restoring_divider_sub_step.sv
// Combinational (WIDTH+1)-bit subtractor built as a ripple borrow chain.
// Produces the trial difference and the final borrow of one divider step.
module sub_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] minuend_i,
    input  logic [WIDTH:0] subtrahend_i,
    output logic [WIDTH:0] diff_o,
    output logic           borrow_o
);

    logic [WIDTH+1:0] borrowChain;

    assign borrowChain[0] = 1'b0;

    // One full-subtractor cell per bit; the borrow ripples towards the MSB.
    for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
        assign diff_o[i] = minuend_i[i] ^ subtrahend_i[i] ^ borrowChain[i];
        assign borrowChain[i+1] = (~minuend_i[i] & subtrahend_i[i]) |
                                  (~(minuend_i[i] ^ subtrahend_i[i]) & borrowChain[i]);
    end

    assign borrow_o = borrowChain[WIDTH+1];

endmodule

// File: rtl/seven_seg.sv
// Hex digit to seven-segment encoder, segments ordered {g,f,e,d,c,b,a},
// active-high.
module seven_seg (
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        case (digit_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define RESTORING_DIVIDER_SEG_EN to add the seg port showing quotient[3:0].
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    restoring_divider_if.slave  bus
`ifdef RESTORING_DIVIDER_SEG_EN
    ,
    output logic [6:0]          seg
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] partRem_q, partRem_d;
    logic [WIDTH-1:0] shiftQ_q, shiftQ_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CW-1:0]    iterCnt_q, iterCnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             divByZero_q, divByZero_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   trialIn;
    logic [WIDTH:0]   trialDiff;
    logic             trialBorrow;
    logic             diffTopUnused;

    // The partial remainder is always below the divisor, so WIDTH bits hold it;
    // the extra bit only matters inside the trial subtraction.
    assign trialIn = {partRem_q, shiftQ_q[WIDTH-1]};
    assign diffTopUnused = trialDiff[WIDTH];

    sub_step #(.WIDTH(WIDTH)) u_subStep (
        .minuend_i    (trialIn),
        .subtrahend_i ({1'b0, divisor_q}),
        .diff_o       (trialDiff),
        .borrow_o     (trialBorrow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            partRem_q   <= '0;
            shiftQ_q    <= '0;
            divisor_q   <= '0;
            iterCnt_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            partRem_q   <= partRem_d;
            shiftQ_q    <= shiftQ_d;
            divisor_q   <= divisor_d;
            iterCnt_q   <= iterCnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divByZero_q <= divByZero_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        partRem_d   = partRem_q;
        shiftQ_d    = shiftQ_q;
        divisor_d   = divisor_q;
        iterCnt_d   = iterCnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divByZero_d = divByZero_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // The dividend is captured on both paths; ZERO reports it back.
                    shiftQ_d = bus.dividend;
                    if (bus.divisor != '0) begin
                        divisor_d = bus.divisor;
                        partRem_d = '0;
                        iterCnt_d = '0;
                        state_d   = CALC;
                    end else begin
                        state_d   = ZERO;
                    end
                end
            end

            CALC: begin
                if (!trialBorrow) begin
                    partRem_d = trialDiff[WIDTH-1:0];
                    shiftQ_d  = {shiftQ_q[WIDTH-2:0], 1'b1};
                end else begin
                    partRem_d = trialIn[WIDTH-1:0];
                    shiftQ_d  = {shiftQ_q[WIDTH-2:0], 1'b0};
                end
                iterCnt_d = iterCnt_q + 1'b1;
                if (iterCnt_q == LAST_ITER) begin
                    quotient_d  = shiftQ_d;
                    remainder_d = partRem_d;
                    divByZero_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end

            ZERO: begin
                quotient_d  = '1;
                remainder_d = shiftQ_q;
                divByZero_d = 1'b1;
                done_d      = 1'b1;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = divByZero_q;

`ifdef RESTORING_DIVIDER_SEG_EN
    logic [3:0] segNibble;

    assign segNibble = 4'(quotient_q);

    seven_seg u_sevenSeg (
        .digit_i (segNibble),
        .seg_o   (seg)
    );
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases from the test plan
// plus randomized traffic compared every cycle against an arithmetic model.
module tb_restoring_divider;
    import restoring_divider_pkg::*;

    localparam int W = DIV_WIDTH;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    restoring_divider_if #(.WIDTH(W)) bus ();

`ifdef RESTORING_DIVIDER_SEG_EN
    logic [6:0] seg;
    restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .seg (seg)
    );
`else
    restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    // Reference model: cycles left in the current operation and the results
    // that become visible when it ends.
    int           left = 0;
    logic         mDone = 1'b0;
    logic [W-1:0] mQuot = '0;
    logic [W-1:0] mRem = '0;
    logic         mDbz = 1'b0;
    logic [W-1:0] pQuot = '0;
    logic [W-1:0] pRem = '0;
    logic         pDbz = 1'b0;

    always @(posedge clk) begin
        mDone = 1'b0;
        if (rst) begin
            left  = 0;
            mQuot = '0;
            mRem  = '0;
            mDbz  = 1'b0;
        end else if (left > 0) begin
            left = left - 1;
            if (left == 0) begin
                mDone = 1'b1;
                mQuot = pQuot;
                mRem  = pRem;
                mDbz  = pDbz;
            end
        end else if (bus.start) begin
            if (bus.divisor == '0) begin
                left  = 1;
                pQuot = '1;
                pRem  = bus.dividend;
                pDbz  = 1'b1;
            end else begin
                left  = W;
                pQuot = bus.dividend / bus.divisor;
                pRem  = bus.dividend % bus.divisor;
                pDbz  = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy", 32'(bus.busy), 32'(left > 0));
            checkOutput("done", 32'(bus.done), 32'(mDone));
            checkOutput("quotient", 32'(bus.quotient), 32'(mQuot));
            checkOutput("remainder", 32'(bus.remainder), 32'(mRem));
            checkOutput("div_by_zero", 32'(bus.div_by_zero), 32'(mDbz));
        end
    end

    task automatic applyStimulus(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
    endtask

    task automatic waitDone(output int lat, output int busyCnt);
        lat = 0;
        busyCnt = 0;
        while (!bus.done && lat < 50) begin
            if (bus.busy) busyCnt++;
            @(negedge clk);
            lat++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("[TB] FAIL doneTimeout: no done within %0d cycles", lat);
        end
    endtask

    task automatic countDones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.done) n++;
            @(negedge clk);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".busy"}, 32'(bus.busy), 0);
        checkOutput({tag, ".done"}, 32'(bus.done), 0);
        checkOutput({tag, ".quotient"}, 32'(bus.quotient), 0);
        checkOutput({tag, ".remainder"}, 32'(bus.remainder), 0);
        checkOutput({tag, ".div_by_zero"}, 32'(bus.div_by_zero), 0);
    endtask

    initial begin
        int lat;
        int busyCnt;
        int n;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        checkEn = 1'b1;
        checkAllZero("reset");
`ifdef RESTORING_DIVIDER_SEG_EN
        checkOutput("seg.reset", 32'(seg), 32'h3F);
`endif
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(13, 3);
        waitDone(lat, busyCnt);
        checkOutput("13/3.latency", lat, W);
        checkOutput("13/3.busyCycles", busyCnt, W);
        checkOutput("13/3.quotient", 32'(bus.quotient), 4);
        checkOutput("13/3.remainder", 32'(bus.remainder), 1);
        checkOutput("13/3.dbz", 32'(bus.div_by_zero), 0);

        applyStimulus(15, 1);
        waitDone(lat, busyCnt);
        checkOutput("15/1.quotient", 32'(bus.quotient), 15);
        checkOutput("15/1.remainder", 32'(bus.remainder), 0);
        applyStimulus(2, 7);
        waitDone(lat, busyCnt);
        checkOutput("2/7.latency", lat, W);
        checkOutput("2/7.quotient", 32'(bus.quotient), 0);
        checkOutput("2/7.remainder", 32'(bus.remainder), 2);
        @(negedge clk);

        applyStimulus(5, 0);
        waitDone(lat, busyCnt);
        checkOutput("5/0.latency", lat, 1);
        checkOutput("5/0.busyCycles", busyCnt, 1);
        checkOutput("5/0.quotient", 32'(bus.quotient), 15);
        checkOutput("5/0.remainder", 32'(bus.remainder), 5);
        checkOutput("5/0.dbz", 32'(bus.div_by_zero), 1);
        @(negedge clk);

        applyStimulus(14, 3);
        applyStimulus(9, 2);
        waitDone(lat, busyCnt);
        checkOutput("14/3.quotient", 32'(bus.quotient), 4);
        checkOutput("14/3.remainder", 32'(bus.remainder), 2);
        @(negedge clk);
        countDones(W + 2, n);
        checkOutput("14/3.noExtraDone", n, 0);

        applyStimulus(12, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("abort");
        countDones(W + 2, n);
        checkOutput("abort.noDone", n, 0);
        applyStimulus(12, 5);
        waitDone(lat, busyCnt);
        checkOutput("12/5.quotient", 32'(bus.quotient), 2);
        checkOutput("12/5.remainder", 32'(bus.remainder), 2);
        @(negedge clk);

`ifdef RESTORING_DIVIDER_SEG_EN
        applyStimulus(9, 3);
        waitDone(lat, busyCnt);
        @(negedge clk);
        checkOutput("seg.9/3", 32'(seg), 32'h4F);
`endif

        // Random traffic: starts at any time, occasional zero divisors and resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.dividend = W'($urandom);
            bus.divisor = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (W + 2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
